rompack_loader: RTL and testbench

//  Consumes the data_io ioctl byte stream for index ROM_INDEX ("Load to ROM Pack", .RMM) and writes it into
//  the ROM-pack SDRAM region; sits between data_io and the sdram controller, in front of the PMD85 core port.

---
 rtl/pmd85_loader_pkg.sv | 14 +
 rtl/rompack_loader_if.sv | 31 +++
 rtl/loader_fifo.sv | 64 ++++++
 rtl/rompack_loader.sv | 143 ++++++++++++++
 tb/tb_rompack_loader.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmd85_loader_pkg.sv
// Shared types and defaults for the PMD85 ROM-pack loader.
package pmd85_loader_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, FLUSH, DONE} loader_state_t;

    localparam logic [23:0] SDRAM_ROMPACK_BASE = 24'h010000;
    localparam int unsigned ROMPACK_MAX_BYTES  = 32768;

    typedef struct packed {
        logic [14:0] offset;
        logic [7:0]  data;
    } fifo_entry_t;

endpackage

// File: rtl/rompack_loader_if.sv
// Bus bundle between data_io, the PMD85 core port and the sdram controller.
interface rompack_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata;
    logic [7:0]  core_rdata;
    logic        core_rd;
    logic        core_wr;
    logic [23:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic [7:0]  sdram_dout;
    logic        sdram_rd;
    logic        sdram_we;
    logic        sdram_ready;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  core_addr, core_wdata, core_rd, core_wr, sdram_dout, sdram_ready,
        output core_rdata, sdram_addr, sdram_din, sdram_rd, sdram_we
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output core_addr, core_wdata, core_rd, core_wr, sdram_dout, sdram_ready,
        input  core_rdata, sdram_addr, sdram_din, sdram_rd, sdram_we
    );
endinterface

// File: rtl/loader_fifo.sv
// Synchronous byte/offset FIFO with a registered head entry; pushes while full are discarded.
module loader_fifo
    import pmd85_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        push_i,
    input  fifo_entry_t wdata_i,
    input  logic        pop_i,
    output fifo_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   rdata_q, rdata_d;
    logic [AW-1:0] wptr_q, rptr_q, rptr_d;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = rdata_q;

    // Head register tracks the entry that will be at the read pointer after this edge.
    always_comb begin
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        rdata_d = mem_q[rptr_d];
        if (do_push && (wptr_q == rptr_d)) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/rompack_loader.sv
// ROM-pack loader: writes ioctl download bytes into SDRAM, passes core traffic when idle.
// Optional ROMPACK_CHECKSUM_EN adds a 16-bit wrapping sum of written bytes.
module rompack_loader
    import pmd85_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  ROM_INDEX  = 8'd1,
    parameter logic [23:0] BASE_ADDR  = SDRAM_ROMPACK_BASE,
    parameter int unsigned MAX_BYTES  = ROMPACK_MAX_BYTES
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    rompack_loader_if.slave        bus,
    output logic                   core_hold,
    output logic                   load_done,
    output logic                   dropped,
    output logic [15:0]            bytes_loaded
`ifdef ROMPACK_CHECKSUM_EN
    ,
    output logic [15:0]            checksum
`endif
);
    loader_state_t state_q, state_d;
    logic [15:0]   bytes_q, bytes_d;
    logic          dropped_q, dropped_d;
    logic          start, wr_hit, oversize, push, pop, fifo_full, fifo_empty;
    fifo_entry_t   push_entry, head;

    assign start    = (state_q == IDLE) && bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
    assign wr_hit   = bus.ioctl_wr && (bus.ioctl_index == ROM_INDEX) &&
                      ((state_q == LOAD) || (state_q == ISSUE));
    assign oversize = (bus.ioctl_addr >= 25'(MAX_BYTES));
    assign push     = wr_hit && !oversize;
    assign pop      = (state_q == ISSUE) && bus.sdram_ready;
    assign push_entry = '{offset: bus.ioctl_addr[14:0], data: bus.ioctl_dout};

    loader_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys(clk_sys),
        .reset  (reset),
        .push_i (push),
        .wdata_i(push_entry),
        .pop_i  (pop),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end else if (!bus.ioctl_download) begin
                    state_d = FLUSH;
                end
            end
            ISSUE:   if (bus.sdram_ready) state_d = LOAD;
            FLUSH:   state_d = fifo_empty ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bytes_d   = bytes_q;
        dropped_d = dropped_q;
        if (start) begin
            bytes_d   = '0;
            dropped_d = 1'b0;
        end else begin
            if (pop && (bytes_q != 16'hFFFF)) begin
                bytes_d = bytes_q + 16'd1;
            end
            if (wr_hit && (oversize || fifo_full)) begin
                dropped_d = 1'b1;
            end
        end
    end

    // Core owns the SDRAM port only while idle; otherwise only the loader may write.
    always_comb begin
        bus.sdram_addr = '0;
        bus.sdram_din  = '0;
        bus.sdram_rd   = 1'b0;
        bus.sdram_we   = 1'b0;
        bus.core_rdata = 8'hFF;
        if (state_q == IDLE) begin
            bus.sdram_addr = {8'd0, bus.core_addr};
            bus.sdram_din  = bus.core_wdata;
            bus.sdram_rd   = bus.core_rd;
            bus.sdram_we   = bus.core_wr;
            bus.core_rdata = bus.sdram_dout;
        end else if (state_q == ISSUE) begin
            bus.sdram_addr = BASE_ADDR + {9'd0, head.offset};
            bus.sdram_din  = head.data;
            bus.sdram_we   = 1'b1;
        end
    end

    assign core_hold    = (state_q != IDLE);
    assign load_done    = (state_q == DONE);
    assign dropped      = dropped_q;
    assign bytes_loaded = bytes_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            bytes_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bytes_q   <= bytes_d;
            dropped_q <= dropped_d;
        end
    end

`ifdef ROMPACK_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + {8'd0, head.data};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_rompack_loader.sv
// Self-checking bench for rompack_loader: directed scenarios plus randomized loads vs a write-list model.
module tb_rompack_loader;
    import pmd85_loader_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        core_hold, load_done, dropped;
    logic [15:0] bytes_loaded;
`ifdef ROMPACK_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    rompack_loader_if bus();

    rompack_loader #(
        .FIFO_DEPTH(8),
        .ROM_INDEX (8'd1),
        .BASE_ADDR (24'h010000),
        .MAX_BYTES (32768)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .bus         (bus),
        .core_hold   (core_hold),
        .load_done   (load_done),
        .dropped     (dropped),
        .bytes_loaded(bytes_loaded)
`ifdef ROMPACK_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int ready_delay = 1;
    int wait_cnt = 0;
    int done_cnt = 0;
    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];

    // SDRAM responder and write/done monitor.
    always @(posedge clk_sys) begin
        if (reset) begin
            bus.sdram_ready <= 1'b0;
            wait_cnt <= 0;
        end else begin
            if (bus.sdram_we && core_hold && !bus.sdram_ready) begin
                if (wait_cnt >= ready_delay) begin
                    bus.sdram_ready <= 1'b1;
                    wait_cnt <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                bus.sdram_ready <= 1'b0;
                if (!bus.sdram_we) wait_cnt <= 0;
            end
            if (bus.sdram_we && bus.sdram_ready && core_hold)
                act_q.push_back({bus.sdram_addr, bus.sdram_din});
            if (load_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        @(negedge clk_sys);
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = d;
        bus.ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr    = 1'b0;
        bus.ioctl_index = 8'd1;
    endtask

    task automatic begin_load();
        act_q.delete();
        exp_q.delete();
        @(negedge clk_sys);
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic finish_load(input string name);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        while (done_cnt == start_cnt && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (3) @(negedge clk_sys);
        checks++;
        if (done_cnt - start_cnt !== 1) begin
            errors++;
            $display("FAIL %s load_done pulses got %0d want 1", name, done_cnt - start_cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({core_hold, load_done, dropped} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {core_hold, load_done, dropped});
        end
        checks++;
        if (bytes_loaded !== 16'd0) begin
            errors++;
            $display("FAIL reset_bytes got %0d want 0", bytes_loaded);
        end
        checks++;
        if ({bus.sdram_we, bus.sdram_rd} !== 2'b00) begin
            errors++;
            $display("FAIL reset_req got %b want 00", {bus.sdram_we, bus.sdram_rd});
        end
    endtask

    task automatic test_basic();
        logic [7:0] data [4];
        data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        ready_delay = 1;
        begin_load();
        bus.core_rd = 1'b1;
        bus.sdram_dout = 8'h3C;
        #1;
        checks++;
        if ({core_hold, bus.sdram_rd, bus.core_rdata} !== {1'b1, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL basic_hold got hold=%b rd=%b rdata=%h want 1 0 ff",
                     core_hold, bus.sdram_rd, bus.core_rdata);
        end
        bus.core_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'd1, 25'(i), data[i]);
            exp_q.push_back({24'h010000 + 24'(i), data[i]});
            repeat (6) @(negedge clk_sys);
        end
        finish_load("basic");
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", act_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d got %h want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({bytes_loaded, dropped} !== {16'd4, 1'b0}) begin
            errors++;
            $display("FAIL basic_stats got bytes=%0d dropped=%b want 4 0", bytes_loaded, dropped);
        end
    endtask

    task automatic test_other_index();
        logic [7:0] d;
        act_q.delete();
        @(negedge clk_sys);
        bus.ioctl_index    = 8'd2;
        bus.ioctl_download = 1'b1;
        repeat (4) @(negedge clk_sys);
        send_byte(8'd2, 25'd0, 8'h11);
        bus.ioctl_index = 8'd2;
        repeat (4) @(negedge clk_sys);
        checks++;
        if ({core_hold, dropped, 1'(act_q.size() != 0)} !== 3'b000) begin
            errors++;
            $display("FAIL other_idle got hold=%b dropped=%b writes=%0d want 0 0 0",
                     core_hold, dropped, act_q.size());
        end
        d = 8'($urandom);
        bus.core_addr  = 16'h1234;
        bus.core_rd    = 1'b1;
        bus.sdram_dout = d;
        #1;
        checks++;
        if ({bus.sdram_addr, bus.sdram_rd, bus.sdram_we, bus.core_rdata} !== {24'h001234, 1'b1, 1'b0, d}) begin
            errors++;
            $display("FAIL pass_read got addr=%h rd=%b we=%b rdata=%h want 001234 1 0 %h",
                     bus.sdram_addr, bus.sdram_rd, bus.sdram_we, bus.core_rdata, d);
        end
        d = 8'($urandom);
        bus.core_rd    = 1'b0;
        bus.core_wr    = 1'b1;
        bus.core_wdata = d;
        #1;
        checks++;
        if ({bus.sdram_we, bus.sdram_din} !== {1'b1, d}) begin
            errors++;
            $display("FAIL pass_write got we=%b din=%h want 1 %h", bus.sdram_we, bus.sdram_din, d);
        end
        @(negedge clk_sys);
        bus.core_wr        = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_overflow();
        ready_delay = 20;
        begin_load();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            bus.ioctl_index = 8'd1;
            bus.ioctl_addr  = 25'(i);
            bus.ioctl_dout  = 8'(i + 64);
            bus.ioctl_wr    = 1'b1;
            if (i < 8) exp_q.push_back({24'h010000 + 24'(i), 8'(i + 64)});
        end
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        checks++;
        if (dropped !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got %b want 1", dropped);
        end
        finish_load("overflow");
        ready_delay = 1;
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL overflow_count got %0d want %0d", act_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL overflow_write%0d got %h want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({bytes_loaded, dropped} !== {16'd8, 1'b1}) begin
            errors++;
            $display("FAIL overflow_stats got bytes=%0d dropped=%b want 8 1", bytes_loaded, dropped);
        end
    endtask

    task automatic test_oversize();
        begin_load();
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL oversize_clear got %b want 0", dropped);
        end
        send_byte(8'd1, 25'd32768, 8'h5A);
        repeat (4) @(negedge clk_sys);
        send_byte(8'd1, 25'd32767, 8'hA5);
        repeat (6) @(negedge clk_sys);
        finish_load("oversize");
        checks++;
        if ({1'(act_q.size() == 1), act_q.size() == 1 ? act_q[0] : 32'h0} !== {1'b1, 24'h017FFF, 8'hA5}) begin
            errors++;
            $display("FAIL oversize_write got n=%0d first=%h want 1 017fffa5",
                     act_q.size(), act_q.size() > 0 ? act_q[0] : 32'h0);
        end
        checks++;
        if ({bytes_loaded, dropped} !== {16'd1, 1'b1}) begin
            errors++;
            $display("FAIL oversize_stats got bytes=%0d dropped=%b want 1 1", bytes_loaded, dropped);
        end
    endtask

    task automatic test_random();
        logic [24:0] a;
        logic [7:0]  d, idx;
        logic        exp_drop;
        logic [15:0] exp_sum;
        for (int l = 0; l < 3; l++) begin
            exp_drop = 1'b0;
            exp_sum  = '0;
            begin_load();
            for (int i = 0; i < int'($urandom_range(4, 9)); i++) begin
                a   = ($urandom_range(0, 7) == 0) ? 25'($urandom_range(32768, 40000))
                                                  : 25'($urandom_range(0, 32767));
                d   = 8'($urandom);
                idx = ($urandom_range(0, 5) == 0) ? 8'd3 : 8'd1;
                send_byte(idx, a, d);
                if (idx == 8'd1) begin
                    if (a >= 25'd32768) begin
                        exp_drop = 1'b1;
                    end else begin
                        exp_q.push_back({24'h010000 + {9'd0, a[14:0]}, d});
                        exp_sum = exp_sum + {8'd0, d};
                    end
                end
                repeat (6) @(negedge clk_sys);
            end
            finish_load("random");
            checks++;
            if (act_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_count got %0d want %0d", l, act_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (act_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL random%0d_write%0d got %h want %h", l, i, act_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if ({bytes_loaded, dropped} !== {16'(exp_q.size()), exp_drop}) begin
                errors++;
                $display("FAIL random%0d_stats got bytes=%0d dropped=%b want %0d %b",
                         l, bytes_loaded, dropped, exp_q.size(), exp_drop);
            end
`ifdef ROMPACK_CHECKSUM_EN
            checks++;
            if (checksum !== exp_sum) begin
                errors++;
                $display("FAIL random%0d_checksum got %h want %h", l, checksum, exp_sum);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int start_cnt;
        ready_delay = 50;
        begin_load();
        send_byte(8'd1, 25'd5, 8'h77);
        n = 0;
        while (!bus.sdram_we && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (bus.sdram_we !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue got we=%b want 1", bus.sdram_we);
        end
        start_cnt = done_cnt;
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({bus.sdram_we, core_hold, load_done, dropped, bytes_loaded} !== {4'b0000, 16'd0}) begin
            errors++;
            $display("FAIL midreset_state got we=%b hold=%b done=%b drop=%b bytes=%0d want 0 0 0 0 0",
                     bus.sdram_we, core_hold, load_done, dropped, bytes_loaded);
        end
        reset = 1'b0;
        ready_delay = 1;
        repeat (10) @(negedge clk_sys);
        checks++;
        if ({1'(done_cnt != start_cnt), 1'(act_q.size() != 0)} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_quiet got done=%0d writes=%0d want 0 0",
                     done_cnt - start_cnt, act_q.size());
        end
        begin_load();
        finish_load("midreset_empty");
        checks++;
        if ({bytes_loaded, 1'(act_q.size() != 0)} !== {16'd0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_fifo got bytes=%0d writes=%0d want 0 0", bytes_loaded, act_q.size());
        end
    endtask

`ifdef ROMPACK_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] data [3];
        data = '{8'h01, 8'hFF, 8'hFF};
        begin_load();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'd1, 25'(i), data[i]);
            repeat (6) @(negedge clk_sys);
        end
        finish_load("checksum");
        checks++;
        if (checksum !== 16'h01FF) begin
            errors++;
            $display("FAIL checksum got %h want 01ff", checksum);
        end
    endtask
`endif

    initial begin
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.core_addr      = '0;
        bus.core_wdata     = '0;
        bus.core_rd        = 1'b0;
        bus.core_wr        = 1'b0;
        bus.sdram_dout     = '0;
        repeat (3) @(negedge clk_sys);
        test_reset();
        reset = 1'b0;
        @(negedge clk_sys);
        test_basic();
        test_other_index();
        test_overflow();
        test_oversize();
        test_random();
        test_reset_mid();
`ifdef ROMPACK_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
